rocker_dir_pulse: RTL

- Converts raw joystick samples from an SPI rocker reader into one-cycle cursor/scroll command pulses (left/right/up/down/click).
- Sits between the SPI rocker front end and the cursor/scroll position registers in the top level.
- Adds threshold hysteresis, a first-press pulse, typematic auto-repeat, a click edge detector and a stale-sample timeout.

---
 rtl/rocker_dir_pulse.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/rocker_dir_pulse.sv
// rocker_dir_pulse
//   Turns raw joystick samples from the SPI rocker reader into one-cycle
//   cursor/scroll command pulses. Each axis has a hysteresis FSM with a
//   first-press pulse and typematic auto-repeat. The stick button is
//   edge-detected into a single click. If samples stop arriving, a stale-sample
//   timeout forces both axes idle.
//
// Ports
//   clk          system clock
//   rst          asynchronous reset, active low
//   sample_valid one-cycle strobe qualifying x_pos / y_pos / btn_raw
//   x_pos        horizontal axis sample, unsigned 10-bit
//   y_pos        vertical axis sample, unsigned 10-bit
//   btn_raw      stick button bit from the same sample
//   left/right   one-cycle X-axis move pulses
//   up/down      one-cycle Y-axis move pulses
//   click        one-cycle pulse on a button press
//   x_active     X axis FSM is not idle
//   y_active     Y axis FSM is not idle
module rocker_dir_pulse #(
  parameter int CENTER        = 512,
  parameter int ENGAGE        = 300,
  parameter int RELEASE       = 200,
  parameter int REPEAT_DELAY  = 40_000_000,
  parameter int REPEAT_PERIOD = 10_000_000,
  parameter int TIMEOUT       = 20_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_valid,
  input  logic [9:0] x_pos,
  input  logic [9:0] y_pos,
  input  logic       btn_raw,
  output logic       left,
  output logic       right,
  output logic       up,
  output logic       down,
  output logic       click,
  output logic       x_active,
  output logic       y_active
);

  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_MAX = (RPT_MAX > TIMEOUT) ? RPT_MAX : TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(TIMEOUT - 1);

  localparam logic signed [10:0] CENTER_S  = 11'(CENTER);
  localparam logic signed [10:0] ENG_POS   = 11'(ENGAGE);
  localparam logic signed [10:0] ENG_NEG   = -11'(ENGAGE);
  localparam logic signed [10:0] REL_POS   = 11'(RELEASE);
  localparam logic signed [10:0] REL_NEG   = -11'(RELEASE);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} axis_state_t;

  // Index 0 is the X axis (pos = right), index 1 is the Y axis (pos = up).
  logic [1:0][9:0]       pos;
  logic signed [10:0]    off [2];
  logic [1:0]            eng_pos;
  logic [1:0]            engage;
  logic [1:0]            in_rel;

  axis_state_t           st [2];
  logic [1:0]            dir;        // 1 = positive direction
  logic [1:0][CNT_W-1:0] cnt;
  logic [1:0]            pulse_pos;
  logic [1:0]            pulse_neg;

  logic [CNT_W-1:0]      tmo_cnt;
  logic                  tmo_fire;
  logic                  btn_latch;

  assign pos = {y_pos, x_pos};

  // Offset from rest and threshold decisions. Equality with +/-ENGAGE does
  // not engage; equality with +/-RELEASE does not release.
  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    for (int a = 0; a < 2; a++) begin
      off[a]     = $signed({1'b0, pos[a]}) - CENTER_S;
      eng_pos[a] = (off[a] > ENG_POS);
      engage[a]  = (off[a] > ENG_POS) || (off[a] < ENG_NEG);
      in_rel[a]  = (off[a] < REL_POS) && (off[a] > REL_NEG);
    end
  end

  // A stale stream only times out in cycles without a fresh sample.
  assign tmo_fire = !sample_valid && (tmo_cnt == TMO_LAST);

  // Per-axis FSMs. Branch order encodes priority: timeout, then an engaging
  // sample (first press or reversal), then release, then repeat expiry. This
  // ordering lets a release/reversal sample suppress a coincident repeat pulse.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the per-axis arrays are small control registers, not memories, so they are all reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int a = 0; a < 2; a++) begin
        st[a] <= IDLE;
      end
      cnt       <= '0;
      dir       <= '0;
      pulse_pos <= '0;
      pulse_neg <= '0;
    end else begin
      for (int a = 0; a < 2; a++) begin
        pulse_pos[a] <= 1'b0;
        pulse_neg[a] <= 1'b0;
        if (tmo_fire) begin
          st[a]  <= IDLE;
          cnt[a] <= '0;
        end else if (sample_valid && engage[a] &&
                     (st[a] == IDLE || dir[a] != eng_pos[a])) begin
          st[a]        <= HOLD;
          dir[a]       <= eng_pos[a];
          cnt[a]       <= '0;
          pulse_pos[a] <= eng_pos[a];
          pulse_neg[a] <= !eng_pos[a];
        end else if (sample_valid && st[a] != IDLE && in_rel[a]) begin
          st[a]  <= IDLE;
          cnt[a] <= '0;
        end else if (st[a] == HOLD && cnt[a] == DELAY_LAST) begin
          st[a]        <= REPEAT;
          cnt[a]       <= '0;
          pulse_pos[a] <= dir[a];
          pulse_neg[a] <= !dir[a];
        end else if (st[a] == REPEAT && cnt[a] == PERIOD_LAST) begin
          cnt[a]       <= '0;
          pulse_pos[a] <= dir[a];
          pulse_neg[a] <= !dir[a];
        end else if (st[a] != IDLE) begin
          cnt[a] <= cnt[a] + CNT_W'(1);
        end
      end
    end
  end

  // Stale-sample timer (saturating) and button edge detector.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt   <= '0;
      btn_latch <= 1'b0;
      click     <= 1'b0;
    end else begin
      click <= sample_valid && btn_raw && !btn_latch;
      if (sample_valid) begin
        tmo_cnt   <= '0;
        btn_latch <= btn_raw;
      end else if (tmo_fire) begin
        btn_latch <= 1'b0;
      end else begin
        tmo_cnt <= tmo_cnt + CNT_W'(1);
      end
    end
  end

  assign right    = pulse_pos[0];
  assign left     = pulse_neg[0];
  assign up       = pulse_pos[1];
  assign down     = pulse_neg[1];
  assign x_active = (st[0] != IDLE);
  assign y_active = (st[1] != IDLE);

endmodule
